// File: rtl/imem_boot_ctrl_if.sv
// Programmer-side load bus. The UART programmer drives it as master and the
// boot controller receives it as slave.
interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              upg_rst_i;
  logic              upg_wen_i;
  logic [ADDR_W:0]   upg_adr_i;
  logic [31:0]       upg_dat_i;
  logic              upg_done_i;

  modport master (
    output upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i
  );

  modport slave (
    input  upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot/load sequencer for the program ROM: hands the ROM port to the UART
// programmer during a load and to instruction fetch otherwise.
module imem_boot_ctrl #(
  parameter int ADDR_W        = 14,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_WORDS     = 16384
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_boot_ctrl_if.slave      upg,
  input  logic [31:0]          cpu_pc_i,
  output logic                 rom_wea_o,
  output logic [ADDR_W-1:0]    rom_addr_o,
  output logic [31:0]          rom_din_o,
  output logic                 dmem_wen_o,
  output logic                 kickoff_o,
  output logic                 inited_o,
  output logic                 cpu_hold_o,
  output logic [ADDR_W:0]      words_loaded_o,
  output logic [31:0]          checksum_o,
  output logic                 load_err_o
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WCNT_W   = ADDR_W + 1;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    RUN    = 2'd1,
    LOAD   = 2'd2
  } state_e;

  state_e              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [ADDR_W-1:0]   expected_addr;
  logic                load_req;
  logic                is_dmem;
  logic                instr_wr;

  assign load_req = ~upg.upg_rst_i & ~upg.upg_done_i;
  assign is_dmem  = upg.upg_adr_i[ADDR_W];
  assign instr_wr = (state == LOAD) & upg.upg_wen_i & ~is_dmem;

  // ROM port mux is combinational so programmer writes land in the strobe cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (an unassigned path in always_comb infers a latch).
    rom_wea_o  = 1'b0;
    dmem_wen_o = 1'b0;
    rom_addr_o = cpu_pc_i[ADDR_W+1:2];
    rom_din_o  = '0;
    if (state == LOAD) begin
      rom_wea_o  = upg.upg_wen_i & ~is_dmem;
      dmem_wen_o = upg.upg_wen_i & is_dmem;
      rom_addr_o = upg.upg_adr_i[ADDR_W-1:0];
      rom_din_o  = upg.upg_dat_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SETTLE;
      settle_cnt     <= '0;
      words_loaded_o <= '0;
      checksum_o     <= '0;
      load_err_o     <= 1'b0;
      expected_addr  <= '0;
      kickoff_o      <= 1'b1;
      inited_o       <= 1'b0;
      cpu_hold_o     <= 1'b1;
    end else begin
      unique case (state)
        SETTLE: begin
          if (load_req) begin
            state          <= LOAD;
            kickoff_o      <= 1'b0;
            words_loaded_o <= '0;
            checksum_o     <= '0;
            load_err_o     <= 1'b0;
            expected_addr  <= '0;
          end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            state      <= RUN;
            inited_o   <= 1'b1;
            cpu_hold_o <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        RUN: begin
          if (load_req) begin
            state          <= LOAD;
            kickoff_o      <= 1'b0;
            inited_o       <= 1'b0;
            cpu_hold_o     <= 1'b1;
            words_loaded_o <= '0;
            checksum_o     <= '0;
            load_err_o     <= 1'b0;
            expected_addr  <= '0;
          end
        end

        LOAD: begin
          // A strobe coinciding with done is still performed and counted.
          if (instr_wr) begin
            checksum_o    <= checksum_o + upg.upg_dat_i;
            expected_addr <= upg.upg_adr_i[ADDR_W-1:0] + 1'b1;
            if (words_loaded_o != WCNT_W'(MAX_WORDS))
              words_loaded_o <= words_loaded_o + 1'b1;
            if (upg.upg_adr_i[ADDR_W-1:0] != expected_addr)
              load_err_o <= 1'b1;
          end
          if (upg.upg_done_i | upg.upg_rst_i) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            kickoff_o  <= 1'b1;
          end
        end

        default: begin
          state      <= SETTLE;
          settle_cnt <= '0;
          kickoff_o  <= 1'b1;
          inited_o   <= 1'b0;
          cpu_hold_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: boot settle, loads, ordering error,
// data-memory writes, checksum wrap and reset during a load.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_pc_i;
  logic        rom_wea_o;
  logic [13:0] rom_addr_o;
  logic [31:0] rom_din_o;
  logic        dmem_wen_o;
  logic        kickoff_o;
  logic        inited_o;
  logic        cpu_hold_o;
  logic [14:0] words_loaded_o;
  logic [31:0] checksum_o;
  logic        load_err_o;

  int checks   = 0;
  int failures = 0;

  imem_boot_ctrl_if #(.ADDR_W(14)) upg ();

  imem_boot_ctrl #(
    .ADDR_W(14), .SETTLE_CYCLES(4), .MAX_WORDS(16384)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .upg            (upg.slave),
    .cpu_pc_i       (cpu_pc_i),
    .rom_wea_o      (rom_wea_o),
    .rom_addr_o     (rom_addr_o),
    .rom_din_o      (rom_din_o),
    .dmem_wen_o     (dmem_wen_o),
    .kickoff_o      (kickoff_o),
    .inited_o       (inited_o),
    .cpu_hold_o     (cpu_hold_o),
    .words_loaded_o (words_loaded_o),
    .checksum_o     (checksum_o),
    .load_err_o     (load_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle programmer strobe; the ROM port is checked before the edge.
  task automatic wr(input logic [14:0] adr, input logic [31:0] dat);
    upg.upg_wen_i = 1'b1;
    upg.upg_adr_i = adr;
    upg.upg_dat_i = dat;
    #1;
    check("wr_rom_wea",  {31'd0, rom_wea_o},  {31'd0, ~adr[14]});
    check("wr_dmem_wen", {31'd0, dmem_wen_o}, {31'd0, adr[14]});
    check("wr_rom_addr", {18'd0, rom_addr_o}, {18'd0, adr[13:0]});
    check("wr_rom_din",  rom_din_o, dat);
    tick();
    upg.upg_wen_i = 1'b0;
  endtask

  // From SETTLE with no load request: inited must rise on exactly the 4th edge.
  task automatic settle_to_run(input string tag);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check({tag, "_inited"}, {31'd0, inited_o}, {31'd0, (i == 4)});
      check({tag, "_hold"},   {31'd0, cpu_hold_o}, {31'd0, (i != 4)});
    end
  endtask

  task automatic enter_load();
    upg.upg_rst_i  = 1'b0;
    upg.upg_done_i = 1'b0;
    tick();
    check("enter_kickoff", {31'd0, kickoff_o}, 32'd0);
  endtask

  task automatic finish_load();
    upg.upg_done_i = 1'b1;
    tick();
    check("done_kickoff", {31'd0, kickoff_o}, 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    cpu_pc_i       = 32'h0;
    upg.upg_rst_i  = 1'b1;
    upg.upg_wen_i  = 1'b0;
    upg.upg_adr_i  = '0;
    upg.upg_dat_i  = '0;
    upg.upg_done_i = 1'b0;

    // Reset and boot settle
    repeat (3) tick();
    check("rst_kickoff", {31'd0, kickoff_o},  32'd1);
    check("rst_inited",  {31'd0, inited_o},   32'd0);
    check("rst_hold",    {31'd0, cpu_hold_o}, 32'd1);
    check("rst_wea",     {31'd0, rom_wea_o},  32'd0);
    check("rst_dmem",    {31'd0, dmem_wen_o}, 32'd0);
    check("rst_words",   {17'd0, words_loaded_o}, 32'd0);
    check("rst_csum",    checksum_o, 32'd0);
    check("rst_err",     {31'd0, load_err_o}, 32'd0);
    reset = 1'b0;
    settle_to_run("boot");

    // Fetch owns the ROM in RUN; programmer strobes are ignored
    cpu_pc_i      = 32'h0000_0010;
    upg.upg_wen_i = 1'b1;
    upg.upg_adr_i = 15'h0007;
    upg.upg_dat_i = 32'hDEAD_BEEF;
    #1;
    check("run_addr", {18'd0, rom_addr_o}, 32'd4);
    check("run_wea",  {31'd0, rom_wea_o},  32'd0);
    check("run_dmem", {31'd0, dmem_wen_o}, 32'd0);
    check("run_din",  rom_din_o, 32'd0);
    tick();
    upg.upg_wen_i = 1'b0;

    // Sequential three-word load
    enter_load();
    check("load1_inited", {31'd0, inited_o}, 32'd0);
    wr(15'd0, 32'h1111_1111);
    wr(15'd1, 32'h2222_2222);
    wr(15'd2, 32'h3333_3333);
    #1;
    check("idle_wea", {31'd0, rom_wea_o}, 32'd0);
    finish_load();
    check("load1_words", {17'd0, words_loaded_o}, 32'd3);
    check("load1_csum",  checksum_o, 32'h6666_6666);
    check("load1_err",   {31'd0, load_err_o}, 32'd0);
    settle_to_run("reload");

    // Out-of-order address sets a sticky error
    enter_load();
    check("load2_words_clr", {17'd0, words_loaded_o}, 32'd0);
    check("load2_csum_clr",  checksum_o, 32'd0);
    wr(15'd0, 32'h1);
    check("load2_err_a", {31'd0, load_err_o}, 32'd0);
    wr(15'd2, 32'h2);
    check("load2_err_b", {31'd0, load_err_o}, 32'd1);
    finish_load();
    settle_to_run("err_run");
    check("err_sticky_run", {31'd0, load_err_o}, 32'd1);
    enter_load();
    check("err_clr_entry", {31'd0, load_err_o}, 32'd0);

    // Data-memory write leaves counters alone
    wr(15'd0, 32'h0000_000A);
    wr(15'h4005, 32'h0000_0055);
    check("dmem_words", {17'd0, words_loaded_o}, 32'd1);
    check("dmem_csum",  checksum_o, 32'h0000_000A);
    finish_load();
    settle_to_run("dmem_run");

    // Checksum wraps; strobe coinciding with done is counted
    enter_load();
    wr(15'd0, 32'hFFFF_FFFF);
    upg.upg_wen_i  = 1'b1;
    upg.upg_adr_i  = 15'd1;
    upg.upg_dat_i  = 32'h0000_0002;
    upg.upg_done_i = 1'b1;
    #1;
    check("done_wr_wea", {31'd0, rom_wea_o}, 32'd1);
    tick();
    upg.upg_wen_i = 1'b0;
    check("wrap_kickoff", {31'd0, kickoff_o}, 32'd1);
    check("wrap_csum",    checksum_o, 32'h0000_0001);
    check("wrap_words",   {17'd0, words_loaded_o}, 32'd2);
    check("wrap_err",     {31'd0, load_err_o}, 32'd0);
    tick();
    check("hold_csum", checksum_o, 32'h0000_0001);

    // Reset in the middle of a load
    enter_load();
    wr(15'd0, 32'h5);
    wr(15'd1, 32'h6);
    check("mid_words_pre", {17'd0, words_loaded_o}, 32'd2);
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    upg.upg_rst_i = 1'b1;
    check("mid_kickoff", {31'd0, kickoff_o}, 32'd1);
    check("mid_words",   {17'd0, words_loaded_o}, 32'd0);
    check("mid_csum",    checksum_o, 32'd0);
    check("mid_inited",  {31'd0, inited_o}, 32'd0);
    upg.upg_wen_i = 1'b1;
    upg.upg_adr_i = 15'd3;
    upg.upg_dat_i = 32'h7;
    #1;
    check("post_rst_wea", {31'd0, rom_wea_o}, 32'd0);
    upg.upg_adr_i = 15'h4003;
    #1;
    check("post_rst_dmem", {31'd0, dmem_wen_o}, 32'd0);
    tick();
    upg.upg_wen_i = 1'b0;
    check("post_rst_words", {17'd0, words_loaded_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot and load sequencer for the single-port program ROM (prgrom) used by the instruction fetch unit.
- Arbitrates the ROM port between the UART programmer (load mode) and CPU fetch (run mode).
- Generates kickoff/inited/hold control for the fetch unit.
- Counts, checksums and checks ordering of loaded instruction words.
- Sits between the UART programmer, prgrom, the data-memory write path and Ifetc32.

Parameters:
ADDR_W, 14, ROM word-address width.
SETTLE_CYCLES, 4, cycles to wait after load completion or reset before the CPU is released (minimum 1).
MAX_WORDS, 16384, saturation limit for words_loaded_o.

Ports:
clk  in  1  system clock; all upg_* inputs are already synchronous to clk.
reset  in  1  synchronous, active-high.
upg_rst_i  in  1  programmer reset; 1 = programmer idle.
upg_wen_i  in  1  single-cycle write strobe from the programmer.
upg_adr_i  in  15  programmer word address; bit 14 = 1 selects data memory.
upg_dat_i  in  32  programmer write data.
upg_done_i  in  1  programmer finished.
cpu_pc_i  in  32  fetch PC (byte address).
rom_wea_o  out  1  ROM write enable.
rom_addr_o  out  14  ROM word address.
rom_din_o  out  32  ROM write data.
dmem_wen_o  out  1  data-memory write strobe (bit-14 writes).
kickoff_o  out  1  1 = normal mode, 0 = load mode.
inited_o  out  1  1 = CPU may fetch; 0 forces PC to 0.
cpu_hold_o  out  1  stall request to the CPU.
words_loaded_o  out  15  instruction words written in the last load.
checksum_o  out  32  mod-2^32 sum of instruction words written in the last load.
load_err_o  out  1  sticky flag: non-sequential instruction address seen.

Behaviour:
- States: SETTLE, RUN, LOAD. State and counters are registered; the ROM port mux is combinational.
- load_req = ~upg_rst_i & ~upg_done_i.
- Reset (any state, including mid-LOAD): state=SETTLE, settle_cnt=0, words_loaded=0, checksum=0, load_err=0, expected_addr=0.
- Reset output values: kickoff_o=1, inited_o=0, cpu_hold_o=1, rom_wea_o=0, dmem_wen_o=0.
- SETTLE:
  - If load_req: go to LOAD.
  - Else if settle_cnt==SETTLE_CYCLES-1: go to RUN.
  - Else: settle_cnt++.
  - Result: RUN is entered exactly SETTLE_CYCLES cycles after reset deasserts with no load_req.
- RUN: if load_req, go to LOAD next cycle.
- Entering LOAD (from SETTLE or RUN): clear words_loaded, checksum, load_err and expected_addr in the same edge.
- LOAD: if upg_done_i | upg_rst_i, go to SETTLE with settle_cnt=0.
- Outputs by state:
  - inited_o = (state==RUN).
  - cpu_hold_o = (state!=RUN).
  - kickoff_o = (state!=LOAD).
- ROM mux in LOAD:
  - rom_wea_o = upg_wen_i & ~upg_adr_i[14]
  - rom_addr_o = upg_adr_i[13:0]
  - rom_din_o = upg_dat_i
  - dmem_wen_o = upg_wen_i & upg_adr_i[14]
  - Zero latency: the write occurs in the same cycle as the strobe.
- ROM mux outside LOAD:
  - rom_wea_o=0, dmem_wen_o=0
  - rom_addr_o = cpu_pc_i[15:2], rom_din_o=0
  - upg_wen_i is ignored.
- Instruction write in LOAD (upg_wen_i & ~adr[14]):
  - checksum += upg_dat_i (wraps mod 2^32).
  - words_loaded++ (saturates at MAX_WORDS).
  - If adr[13:0] != expected_addr, set load_err (sticky until the next LOAD entry).
  - expected_addr = adr[13:0]+1 (wraps at 2^14).
- Data writes (bit 14 = 1) do not affect the counters or the checksum.
- Write strobe in the same cycle as upg_done_i: the write is performed and counted, then the state moves to SETTLE.
- words_loaded_o, checksum_o and load_err_o hold their values through SETTLE and RUN until the next LOAD entry.

Test Plan:
- Reset held 3 cycles, then released, upg_rst_i=1 -> inited_o=0 and cpu_hold_o=1 for 4 cycles, then inited_o=1; cpu_pc_i=0x0000_0010 gives rom_addr_o=4, rom_wea_o=0.
- From RUN, upg_rst_i=0, upg_done_i=0; write 0x11111111, 0x22222222, 0x33333333 at addresses 0, 1, 2; then upg_done_i=1:
  - rom_wea_o pulses in the same cycles as the strobes.
  - words_loaded_o=3, checksum_o=0x66666666, load_err_o=0.
  - RUN is re-entered 4 cycles after done.
- In LOAD, write addresses 0 then 2 -> load_err_o=1 after the second write; it stays 1 in RUN and clears on the next LOAD entry.
- In LOAD, write to upg_adr_i=0x4005 -> dmem_wen_o=1 and rom_wea_o=0; words_loaded_o and checksum_o unchanged.
- Write 0xFFFFFFFF then 0x00000002 -> checksum_o=0x00000001. A write in the same cycle as upg_done_i is counted.
- Reset asserted mid-LOAD after 2 writes -> next cycle state=SETTLE, words_loaded_o=0, kickoff_o=1; a later upg_wen_i with upg_rst_i=1 gives no ROM write.
